// File: rtl/sa_gemm_core.sv
// N x N output-stationary systolic GEMM core with input skew, start/busy/done control and per-job clear.
// Latency: PE(r,c) accumulates beat E at edge E+r+c+1; done asserts at edge E_last+2N-1 (k_len=0: next edge).
// Backpressure: in_ready high only in LOAD; input gaps become bubbles. Optional SA_SAT_EN enables saturating accumulate.
module sa_gemm_core #(
    parameter int WIDTH = 8,
    parameter int ACC   = 32,
    parameter int N     = 4,
    parameter int KW    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [KW-1:0]        k_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WIDTH-1:0]   a_in,
    input  logic [N*WIDTH-1:0]   b_in,
    output logic                 busy,
    output logic                 done,
    output logic [N*N*ACC-1:0]   acc_out,
    output logic                 sat_flag
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    localparam int DW = $clog2(2 * N);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(2 * N - 2);
    localparam logic [KW-1:0] K_ONE      = KW'(1);

    state_t          state, state_nx;
    logic [KW-1:0]   k_reg;
    logic [KW-1:0]   beat_cnt;
    logic [DW-1:0]   drain_cnt;
    logic            start_ok;
    logic            accept;
    logic            last_beat;
    logic            drain_end;
    logic            done_set;

    // skew registers: row/column x uses stages 0..x
    logic signed [WIDTH-1:0] a_sk   [N][N];
    logic                    a_sk_v [N][N];
    logic signed [WIDTH-1:0] b_sk   [N][N];
    logic                    b_sk_v [N][N];

    // inter-PE forwarding registers
    logic signed [WIDTH-1:0] a_pipe   [N][N];
    logic                    a_pipe_v [N][N];
    logic signed [WIDTH-1:0] b_pipe   [N][N];
    logic                    b_pipe_v [N][N];

    // operands presented to each PE
    logic signed [WIDTH-1:0] a_op   [N][N];
    logic                    a_op_v [N][N];
    logic signed [WIDTH-1:0] b_op   [N][N];
    logic                    b_op_v [N][N];

    logic signed [2*WIDTH-1:0] prod   [N][N];
    logic signed [ACC-1:0]     acc    [N][N];
    logic signed [ACC-1:0]     acc_nx [N][N];

`ifdef SA_SAT_EN
    localparam logic signed [ACC-1:0] ACC_MAX = {1'b0, {(ACC-1){1'b1}}};
    localparam logic signed [ACC-1:0] ACC_MIN = {1'b1, {(ACC-1){1'b0}}};
    logic signed [ACC:0] sum_w [N][N];
    logic [N*N-1:0]      sat_ev;
`endif

    assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
    assign accept    = in_valid && in_ready;
    assign last_beat = accept && (beat_cnt == (k_reg - K_ONE));
    assign drain_end = (state == S_DRAIN) && (drain_cnt == DRAIN_LAST);

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nx = (k_len == '0) ? S_DONE : S_LOAD;
            S_LOAD:         if (last_beat) state_nx = S_DRAIN;
            S_DRAIN:        if (drain_end) state_nx = S_DONE;
            default:        state_nx = S_IDLE;
        endcase
    end

    // state-decoded outputs; done is a registered pulse on entry into DONE
    always_comb begin
        in_ready = (state == S_LOAD);
        busy     = (state == S_LOAD) || (state == S_DRAIN);
        done_set = (state_nx == S_DONE) && (start_ok || (state == S_DRAIN));
    end

    // job bookkeeping: k latch, beat and drain counters, done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            k_reg     <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            done      <= 1'b0;
        end else begin
            done <= done_set;
            if (start_ok) begin
                k_reg    <= k_len;
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + K_ONE;
            end
            if (last_beat)             drain_cnt <= '0;
            else if (state == S_DRAIN) drain_cnt <= drain_cnt + DW'(1);
        end
    end

    // input skew: stage 0 captures the beat (or a bubble), later stages shift
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int x = 0; x < N; x++) begin
                for (int j = 0; j < N; j++) begin
                    a_sk[x][j]   <= '0;
                    a_sk_v[x][j] <= 1'b0;
                    b_sk[x][j]   <= '0;
                    b_sk_v[x][j] <= 1'b0;
                end
            end
        end else begin
            for (int x = 0; x < N; x++) begin
                a_sk[x][0]   <= accept ? a_in[x*WIDTH +: WIDTH] : '0;
                a_sk_v[x][0] <= accept;
                b_sk[x][0]   <= accept ? b_in[x*WIDTH +: WIDTH] : '0;
                b_sk_v[x][0] <= accept;
                for (int j = 1; j < N; j++) begin
                    if (j <= x) begin
                        a_sk[x][j]   <= a_sk[x][j-1];
                        a_sk_v[x][j] <= a_sk_v[x][j-1];
                        b_sk[x][j]   <= b_sk[x][j-1];
                        b_sk_v[x][j] <= b_sk_v[x][j-1];
                    end
                end
            end
        end
    end

    // operand routing: array edges take the skew taps, interior takes neighbours
    always_comb begin
        for (int r = 0; r < N; r++) begin
            a_op[r][0]   = a_sk[r][r];
            a_op_v[r][0] = a_sk_v[r][r];
            for (int c = 1; c < N; c++) begin
                a_op[r][c]   = a_pipe[r][c-1];
                a_op_v[r][c] = a_pipe_v[r][c-1];
            end
        end
        for (int c = 0; c < N; c++) begin
            b_op[0][c]   = b_sk[c][c];
            b_op_v[0][c] = b_sk_v[c][c];
            for (int r = 1; r < N; r++) begin
                b_op[r][c]   = b_pipe[r-1][c];
                b_op_v[r][c] = b_pipe_v[r-1][c];
            end
        end
    end

    // PE forwarding: A moves right, B moves down, one PE per cycle
    always_ff @(posedge clk) begin
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (rst) begin
                    a_pipe[r][c]   <= '0;
                    a_pipe_v[r][c] <= 1'b0;
                    b_pipe[r][c]   <= '0;
                    b_pipe_v[r][c] <= 1'b0;
                end else begin
                    a_pipe[r][c]   <= a_op[r][c];
                    a_pipe_v[r][c] <= a_op_v[r][c];
                    b_pipe[r][c]   <= b_op[r][c];
                    b_pipe_v[r][c] <= b_op_v[r][c];
                end
            end
        end
    end

    // multiply-accumulate datapath (wrapping, or saturating with SA_SAT_EN)
    always_comb begin
`ifdef SA_SAT_EN
        sat_ev = '0;
`endif
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                prod[r][c] = a_op[r][c] * b_op[r][c];
`ifdef SA_SAT_EN
                sum_w[r][c] = (ACC+1)'(acc[r][c]) + (ACC+1)'(prod[r][c]);
                if (sum_w[r][c][ACC] != sum_w[r][c][ACC-1]) begin
                    acc_nx[r][c]   = sum_w[r][c][ACC] ? ACC_MIN : ACC_MAX;
                    sat_ev[r*N+c]  = a_op_v[r][c] && b_op_v[r][c];
                end else begin
                    acc_nx[r][c]   = sum_w[r][c][ACC-1:0];
                end
`else
                acc_nx[r][c] = acc[r][c] + ACC'(prod[r][c]);
`endif
            end
        end
    end

    // accumulators: cleared by reset or an accepted start, update on valid tags
    always_ff @(posedge clk) begin
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (rst || start_ok)                          acc[r][c] <= '0;
                else if (a_op_v[r][c] && b_op_v[r][c])        acc[r][c] <= acc_nx[r][c];
            end
        end
    end

`ifdef SA_SAT_EN
    // sticky saturation indicator, cleared per job
    always_ff @(posedge clk) begin
        if (rst || start_ok) sat_flag <= 1'b0;
        else if (|sat_ev)    sat_flag <= 1'b1;
    end
`else
    assign sat_flag = 1'b0;
`endif

    // flatten accumulators onto the result bus
    always_comb begin
        acc_out = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                acc_out[(r*N+c)*ACC +: ACC] = acc[r][c];
            end
        end
    end

endmodule

// File: tb/tb_sa_gemm_core.sv
// Self-checking bench for sa_gemm_core: directed jobs plus randomized jobs against a matrix-product model.
// A second small instance (N=1, ACC=16) exercises the overflow behaviour in either build.
// Expected overflow results follow SA_SAT_EN.
module tb_sa_gemm_core;

    localparam int WIDTH = 8;
    localparam int ACC   = 32;
    localparam int N     = 4;
    localparam int KW    = 16;
    localparam int KMAX  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, start, in_valid, in_ready, busy, done, sat_flag;
    logic [KW-1:0]        k_len;
    logic [N*WIDTH-1:0]   a_in, b_in;
    logic [N*N*ACC-1:0]   acc_out;

    logic                 s_start, s_in_valid, s_in_ready, s_busy, s_done, s_sat_flag;
    logic [KW-1:0]        s_k_len;
    logic [WIDTH-1:0]     s_a_in, s_b_in;
    logic [15:0]          s_acc_out;

    sa_gemm_core #(.WIDTH(WIDTH), .ACC(ACC), .N(N), .KW(KW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .in_valid(in_valid),
        .in_ready(in_ready), .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
        .acc_out(acc_out), .sat_flag(sat_flag)
    );

    sa_gemm_core #(.WIDTH(WIDTH), .ACC(16), .N(1), .KW(KW)) u_sat (
        .clk(clk), .rst(rst), .start(s_start), .k_len(s_k_len), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .a_in(s_a_in), .b_in(s_b_in), .busy(s_busy), .done(s_done),
        .acc_out(s_acc_out), .sat_flag(s_sat_flag)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int e_last  = 0;
    int done_edge = 0;
    int A [N][KMAX];
    int B [KMAX][N];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_ops();
        for (int i = 0; i < KMAX; i++)
            for (int x = 0; x < N; x++) begin
                A[x][i] = 0;
                B[i][x] = 0;
            end
    endtask

    task automatic gen(input int k);
        clear_ops();
        for (int i = 0; i < k; i++)
            for (int x = 0; x < N; x++) begin
                A[x][i] = int'($urandom_range(0, 255)) - 128;
                B[i][x] = int'($urandom_range(0, 255)) - 128;
            end
    endtask

    task automatic start_job(input int k);
        start = 1'b1;
        k_len = KW'(k);
        tick();
        start = 1'b0;
    endtask

    // drive nb beats; optional gap cycles between beats; poke raises start mid-LOAD
    task automatic feed(input int nb, input int gap, input bit poke, input bit full);
        for (int i = 0; i < nb; i++) begin
            for (int x = 0; x < N; x++) begin
                a_in[x*WIDTH +: WIDTH] = WIDTH'(A[x][i]);
                b_in[x*WIDTH +: WIDTH] = WIDTH'(B[i][x]);
            end
            in_valid = 1'b1;
            if (poke && i == 1) begin
                start = 1'b1;
                k_len = KW'(7);
            end
            check($sformatf("in_ready_beat%0d", i), in_ready, 1);
            tick();
            e_last   = cyc;
            in_valid = 1'b0;
            start    = 1'b0;
            a_in     = '0;
            b_in     = '0;
            if (i < nb - 1) repeat (gap) tick();
        end
        if (full) check("in_ready_after_last", in_ready, 0);
    endtask

    task automatic wait_done(input string tag);
        int w = 0;
        while (!done && w < 100) begin
            tick();
            w++;
        end
        check($sformatf("%s_done_seen", tag), done, 1);
        done_edge = cyc;
    endtask

    task automatic check_result(input string tag, input int k);
        longint s;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                s = 0;
                for (int i = 0; i < k; i++) s += longint'(A[r][i]) * longint'(B[i][c]);
                check($sformatf("%s_c%0d%0d", tag, r, c), $signed(acc_out[(r*N+c)*ACC +: ACC]), s);
            end
    endtask

    task automatic finish_checks(input string tag, input int k);
        check($sformatf("%s_latency", tag), done_edge - e_last, 2*N - 1);
        check($sformatf("%s_busy_at_done", tag), busy, 0);
        check($sformatf("%s_sat_flag", tag), sat_flag, 0);
        check_result(tag, k);
    endtask

    task automatic run_job(input string tag, input int k, input int gap);
        start_job(k);
        feed(k, gap, 1'b0, 1'b1);
        wait_done(tag);
        finish_checks(tag, k);
    endtask

    initial begin
        int k, gap, w;
        longint s_exp;
        bit sat_exp;

        rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0; a_in = '0; b_in = '0;
        s_start = 1'b0; s_k_len = '0; s_in_valid = 1'b0; s_a_in = '0; s_b_in = '0;
        repeat (3) tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sat_flag", sat_flag, 0);
        check("rst_acc_zero", (acc_out == '0), 1);
        rst = 1'b0;
        tick();

        // small product on the top-left 2x2 corner
        clear_ops();
        A[0][0] = 3; A[1][0] = 4; B[0][0] = 5; B[0][1] = 6;
        run_job("t1", 1, 0);
        check("t1_c00_const", $signed(acc_out[0 +: ACC]), 15);
        check("t1_c11_const", $signed(acc_out[(1*N+1)*ACC +: ACC]), 24);
        tick();
        check("t1_done_one_cycle", done, 0);

        // random K=3 with two idle cycles between beats
        gen(3);
        run_job("t2", 3, 2);

        // signed corner values
        clear_ops();
        A[0][0] = -128; A[1][0] = -3; B[0][0] = -128; B[0][1] = 7;
        run_job("t3", 1, 0);
        check("t3_c01_const", $signed(acc_out[1*ACC +: ACC]), -896);
        check("t3_c10_const", $signed(acc_out[(1*N)*ACC +: ACC]), 384);

        // mid-LOAD start ignored, then a new job started in the done cycle
        gen(4);
        start_job(4);
        feed(4, 1, 1'b1, 1'b1);
        wait_done("t4a");
        finish_checks("t4a", 4);
        gen(2);
        start_job(2);
        check("t4_done_cleared", done, 0);
        check("t4_busy_restart", busy, 1);
        feed(2, 0, 1'b0, 1'b1);
        wait_done("t4b");
        finish_checks("t4b", 2);

        // reset in the middle of a load
        gen(4);
        start_job(4);
        feed(2, 0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        check("t5_rst_in_ready", in_ready, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        check("t5_rst_acc_zero", (acc_out == '0), 1);
        rst = 1'b0;
        tick();
        gen(3);
        run_job("t5", 3, 1);
        start_job(0);
        check("t5_k0_done", done, 1);
        check("t5_k0_busy", busy, 0);
        check("t5_k0_acc_zero", (acc_out == '0), 1);
        tick();
        check("t5_k0_done_one_cycle", done, 0);

        // randomized jobs
        for (int j = 0; j < 6; j++) begin
            k   = int'($urandom_range(1, KMAX));
            gap = int'($urandom_range(0, 3));
            gen(k);
            run_job($sformatf("rnd%0d", j), k, gap);
        end

        // overflow behaviour on the narrow instance
        s_exp = 0;
        sat_exp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_exp += 127 * 127;
`ifdef SA_SAT_EN
            if (s_exp > 32767) begin
                s_exp = 32767;
                sat_exp = 1'b1;
            end
`endif
        end
`ifndef SA_SAT_EN
        s_exp = ((s_exp + 32768) % 65536) - 32768;
`endif
        s_start = 1'b1;
        s_k_len = KW'(3);
        tick();
        s_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_a_in = 8'd127;
            s_b_in = 8'd127;
            s_in_valid = 1'b1;
            check($sformatf("sat_in_ready%0d", i), s_in_ready, 1);
            tick();
            e_last = cyc;
        end
        s_in_valid = 1'b0;
        w = 0;
        while (!s_done && w < 50) begin
            tick();
            w++;
        end
        check("sat_done_seen", s_done, 1);
        check("sat_latency", cyc - e_last, 1);
        check("sat_busy", s_busy, 0);
        check("sat_acc", $signed(s_acc_out), s_exp);
        check("sat_flag", s_sat_flag, sat_exp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sa_gemm_core.md
Name: sa_gemm_core

Overview:
- Parametrised N x N output-stationary systolic matrix-multiply core. Successor to the fixed 2x2 array.
- Adds built-in input skewing, a valid/ready input stream, a start/busy/done control FSM, a programmable reduction length K, and accumulator clear per job.
- Computes C = A x B. A is N x K, streamed one column per beat. B is K x N, streamed one row per beat.
- Sits between the operand buffers and the result writeback.

Parameters:
- WIDTH, 8: signed operand width.
- ACC, 32: signed accumulator width. Must be ≥ 2*WIDTH.
- N, 4: array dimension (N x N PEs). Must be ≥ 1.
- KW, 16: width of the k_len field.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle job start. Honoured only when busy=0.
- k_len  in  KW  reduction length K. Sampled on the start edge.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  core accepts a beat this cycle.
- a_in  in  N*WIDTH  A column. Element r at [r*WIDTH +: WIDTH].
- b_in  in  N*WIDTH  B row. Element c at [c*WIDTH +: WIDTH].
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse when results are final.
- acc_out  out  N*N*ACC  C(r,c) at [(r*N+c)*ACC +: ACC]. Registered.
- sat_flag  out  1  sticky overflow indicator (see Optional Feature).

Behaviour:
- Reset, applied on any edge with rst=1, including mid-job:
  - FSM goes to IDLE.
  - in_ready=0, busy=0, done=0, sat_flag=0.
  - All acc_out = 0.
  - All skew/pipeline data and valid-tag registers cleared.
- FSM states: IDLE, LOAD, DRAIN, DONE.
- IDLE/DONE, start=1:
  - Clear all accumulators and sat_flag on that edge.
  - Latch k_len.
  - Beat counter := 0.
  - If k_len ≠ 0, go to LOAD. If k_len = 0, go to DONE, and done pulses the next cycle with acc_out all zero.
- start while busy=1 is ignored.
- busy=1 in LOAD and DRAIN. in_ready=1 only in LOAD.
- Accept = in_valid & in_ready. Each accepted beat increments the beat counter.
  - When the accepted beat is number K, go to DRAIN on that edge.
  - in_ready is 0 from the next cycle.
- Skew:
  - a_in[r] is delayed by r registers, then travels right one PE per cycle.
  - b_in[c] is delayed by c registers, then travels down one PE per cycle.
  - A valid tag travels with each datum.
  - Cycles with no accept inject bubbles (tag=0, data=0). PEs accumulate only when the tag is 1.
  - Input gaps therefore never change results.
- Timing: PE(r,c) accumulates the product of the beat accepted at edge E on edge E+r+c+1.
- DRAIN lasts exactly 2N-1 cycles after the last-accept edge E_last.
  - On edge E_last+2N-1: go to DONE and set done=1.
  - done is high for exactly one cycle.
- DONE:
  - busy=0.
  - acc_out holds until the next accepted start or rst.
  - A start is allowed in the same cycle done is high.
- Arithmetic:
  - Product is signed WIDTH x WIDTH, full 2*WIDTH bits, sign-extended to ACC.
  - Accumulation wraps modulo 2^ACC unless SA_SAT_EN is defined.

Optional Feature:
- Macro: SA_SAT_EN.
- Defined:
  - Each accumulate saturates to [-2^(ACC-1), 2^(ACC-1)-1].
  - Any saturation event sets sat_flag. It is sticky until the next start or rst.
- Undefined:
  - Two's-complement wrap.
  - sat_flag is tied to 0.
  - No saturation logic is synthesised.

Test Plan:
1. N=2, start with k_len=1, beat a=[3,4], b=[5,6]:
   - acc_out = [[15,18],[20,24]].
   - done pulses 3 cycles after the accept edge.
   - busy falls with done.
2. N=4, K=3 random A/B, in_valid low for 2 cycles between beats:
   - acc_out equals the golden A x B.
   - done occurs at E_last+7, regardless of the gaps.
3. N=2, K=1, signed corners a=[-128,-3], b=[-128,7]:
   - C(0,0)=16384, C(1,1)=-21, C(0,1)=-896, C(1,0)=384.
4. Back-to-back jobs with start issued in the done cycle:
   - Second job's results contain no residue from the first.
   - start asserted mid-LOAD is ignored.
5. rst pulsed mid-LOAD after 2 of K=4 beats:
   - Next cycle all outputs are 0 and in_ready=0.
   - A new job then completes correctly.
   - k_len=0 start gives done on the next cycle with all zeros.
6. ACC=16, N=1, K=3 beats of 127*127:
   - With SA_SAT_EN: acc_out=32767, sat_flag=1.
   - Without: acc_out=-17149, sat_flag=0.
